// File: rtl/ip_pipe_pkg.sv
// ip_pipe_pkg: shared pipeline definitions for the ID hazard scheduler.
// Holds the result-valid stage codes, the bypass-source encodings, the
// scoreboard entry type and small helpers shared by the scoreboard files.
// Feature macro used by the scoreboard: IP_BYPASS_SCOREBOARD_FORWARD_EN.
package ip_pipe_pkg;

    // Width of a register number as stored in a scoreboard entry.
    localparam int PKG_REG_AW = 5;

    // One-hot stage at which a writer's result becomes valid.
    localparam logic [2:0] STG_NONE = 3'b000;
    localparam logic [2:0] STG_EXE  = 3'b001;
    localparam logic [2:0] STG_MEM  = 3'b010;
    localparam logic [2:0] STG_WB   = 3'b100;

    // Operand source selected for an ID read.
    localparam logic [1:0] SRC_RF  = 2'd0;
    localparam logic [1:0] SRC_EXE = 2'd1;
    localparam logic [1:0] SRC_MEM = 2'd2;
    localparam logic [1:0] SRC_WB  = 2'd3;

    // One in-flight writer: valid, destination register, result-valid stage.
    typedef struct packed {
        logic                  v;
        logic [PKG_REG_AW-1:0] waddr;
        logic [2:0]            wstage;
    } sb_entry_t;

    // An instruction writes the register file only with a real destination
    // and a real result-valid stage.
    function automatic logic is_writer(input logic [PKG_REG_AW-1:0] w_addr,
                                       input logic [2:0]            w_stage);
        return (w_addr != {PKG_REG_AW{1'b0}}) && (w_stage != STG_NONE);
    endfunction

    // Whether a writer sitting at the stage named by 'at_src' already has
    // its result: an EXE writer is ready everywhere, a MEM writer from MEM
    // onwards, and anything in WB is ready.
    function automatic logic stage_ready(input logic [2:0] wstage,
                                         input logic [1:0] at_src);
        logic rdy;
        case (at_src)
            SRC_EXE: rdy = wstage[0];
            SRC_MEM: rdy = wstage[0] | wstage[1];
            SRC_WB:  rdy = 1'b1;
            default: rdy = 1'b0;
        endcase
        return rdy;
    endfunction

endpackage

// File: rtl/ip_src_resolve.sv
// ip_src_resolve: hazard resolution for a single ID source operand.
// Finds the youngest valid writer of the source register among E, M, W and
// reports whether ID must stall and which stage supplies the operand.
// With IP_BYPASS_SCOREBOARD_FORWARD_EN undefined there is no bypass: any
// matching in-flight writer stalls and the select stays on the register file.
module ip_src_resolve
    import ip_pipe_pkg::*;
(
    input  logic [PKG_REG_AW-1:0] r_addr,
    input  sb_entry_t             ent_e,
    input  sb_entry_t             ent_m,
    input  sb_entry_t             ent_w,
    output logic                  stall,
    output logic [1:0]            sel
);

    logic rd_s;
    logic hit_e_s;
    logic hit_m_s;
    logic hit_w_s;
    logic unused_wstage_s;

    // Register 0 is never read, so it never matches a producer.
    assign rd_s    = (r_addr != {PKG_REG_AW{1'b0}});
    assign hit_e_s = rd_s & ent_e.v & (ent_e.waddr == r_addr);
    assign hit_m_s = rd_s & ent_m.v & (ent_m.waddr == r_addr);
    assign hit_w_s = rd_s & ent_w.v & (ent_w.waddr == r_addr);

    // Not every stage-code bit matters in every build.
    assign unused_wstage_s = ^{ent_e.wstage, ent_m.wstage, ent_w.wstage};

    // Priority pick of the youngest matching producer, E before M before W.
    always_comb begin
        stall = 1'b0;
        sel   = SRC_RF;
        if (hit_e_s) begin
`ifdef IP_BYPASS_SCOREBOARD_FORWARD_EN
            if (stage_ready(ent_e.wstage, SRC_EXE)) begin
                sel = SRC_EXE;
            end else begin
                stall = 1'b1;
            end
`else
            stall = 1'b1;
`endif
        end else if (hit_m_s) begin
`ifdef IP_BYPASS_SCOREBOARD_FORWARD_EN
            if (stage_ready(ent_m.wstage, SRC_MEM)) begin
                sel = SRC_MEM;
            end else begin
                stall = 1'b1;
            end
`else
            stall = 1'b1;
`endif
        end else if (hit_w_s) begin
`ifdef IP_BYPASS_SCOREBOARD_FORWARD_EN
            if (stage_ready(ent_w.wstage, SRC_WB)) begin
                sel = SRC_WB;
            end else begin
                stall = 1'b1;
            end
`else
            // No write-through: wait until the producer has retired.
            stall = 1'b1;
`endif
        end else begin
            stall = 1'b0;
            sel   = SRC_RF;
        end
    end

endmodule

// File: rtl/ip_bypass_scoreboard.sv
// ip_bypass_scoreboard: ID-stage hazard scheduler and bypass selector.
// Mirrors the writers held in the EXE, MEM and WB pipeline registers and,
// for the instruction in ID, decides stall and per-operand bypass source.
// Outputs are combinational from the mirrored entries and the ID inputs.
// Feature macro: IP_BYPASS_SCOREBOARD_FORWARD_EN (undefined = no bypass).
module ip_bypass_scoreboard
    import ip_pipe_pkg::*;
#(
    // Must equal PKG_REG_AW, the width stored in each entry.
    parameter int REG_AW = PKG_REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_r_addr1,
    input  logic [REG_AW-1:0] id_r_addr2,
    input  logic [REG_AW-1:0] id_w_addr,
    input  logic [2:0]        id_w_stage,
    input  logic              id_fire,
    input  logic              exe_fire,
    input  logic              mem_fire,
    input  logic              wb_fire,
    output logic              id_stall,
    output logic [1:0]        src1_sel,
    output logic [1:0]        src2_sel
);

    sb_entry_t  ent_e_r;
    sb_entry_t  ent_m_r;
    sb_entry_t  ent_w_r;
    sb_entry_t  id_entry_s;

    logic       stall1_s;
    logic       stall2_s;
    logic [1:0] sel1_s;
    logic [1:0] sel2_s;

    // Entry for the ID instruction; a non-writer enters E as invalid.
    always_comb begin
        id_entry_s.v      = is_writer(id_w_addr, id_w_stage);
        id_entry_s.waddr  = id_w_addr;
        id_entry_s.wstage = id_w_stage;
    end

    // E entry follows the ID->EXE register; retiring out of EXE empties it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_e_r <= '0;
        end else if (id_fire) begin
            ent_e_r <= id_entry_s;
        end else if (exe_fire) begin
            ent_e_r.v <= 1'b0;
        end else begin
            ent_e_r <= ent_e_r;
        end
    end

    // M entry follows the EXE->MEM register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_m_r <= '0;
        end else if (exe_fire) begin
            ent_m_r <= ent_e_r;
        end else if (mem_fire) begin
            ent_m_r.v <= 1'b0;
        end else begin
            ent_m_r <= ent_m_r;
        end
    end

    // W entry follows the MEM->WB register; WB retire empties it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_w_r <= '0;
        end else if (mem_fire) begin
            ent_w_r <= ent_m_r;
        end else if (wb_fire) begin
            ent_w_r.v <= 1'b0;
        end else begin
            ent_w_r <= ent_w_r;
        end
    end

    ip_src_resolve u_src1 (
        .r_addr (id_r_addr1),
        .ent_e  (ent_e_r),
        .ent_m  (ent_m_r),
        .ent_w  (ent_w_r),
        .stall  (stall1_s),
        .sel    (sel1_s)
    );

    ip_src_resolve u_src2 (
        .r_addr (id_r_addr2),
        .ent_e  (ent_e_r),
        .ent_m  (ent_m_r),
        .ent_w  (ent_w_r),
        .stall  (stall2_s),
        .sel    (sel2_s)
    );

    // Only a valid ID instruction can stall or steer the bypass muxes.
    always_comb begin
        if (id_valid) begin
            id_stall = stall1_s | stall2_s;
            src1_sel = sel1_s;
            src2_sel = sel2_s;
        end else begin
            id_stall = 1'b0;
            src1_sel = SRC_RF;
            src2_sel = SRC_RF;
        end
    end

endmodule

// File: tb/tb_ip_bypass_scoreboard.sv
// tb_ip_bypass_scoreboard: directed bench for ip_bypass_scoreboard.
// Keeps a list of in-flight writers (destination, ready stage, current
// stage) and derives stall/select from it every cycle; a few literal
// expectations pin the model. Follows IP_BYPASS_SCOREBOARD_FORWARD_EN.
module tb_ip_bypass_scoreboard;

`ifdef IP_BYPASS_SCOREBOARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_r_addr1;
    logic [4:0] id_r_addr2;
    logic [4:0] id_w_addr;
    logic [2:0] id_w_stage;
    logic       id_fire;
    logic       exe_fire;
    logic       mem_fire;
    logic       wb_fire;
    logic       id_stall;
    logic [1:0] src1_sel;
    logic [1:0] src2_sel;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // In-flight writer: stage numbers are 1 EXE, 2 MEM, 3 WB.
    typedef struct {
        int dst;
        int rdy;
        int stg;
    } fl_t;
    fl_t inflight[$];

    ip_bypass_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_r_addr1 (id_r_addr1),
        .id_r_addr2 (id_r_addr2),
        .id_w_addr  (id_w_addr),
        .id_w_stage (id_w_stage),
        .id_fire    (id_fire),
        .exe_fire   (exe_fire),
        .mem_fire   (mem_fire),
        .wb_fire    (wb_fire),
        .id_stall   (id_stall),
        .src1_sel   (src1_sel),
        .src2_sel   (src2_sel)
    );

    always #5 clk = ~clk;

    function automatic int stage_num(input logic [2:0] ws);
        case (ws)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 3;
            default: return 0;
        endcase
    endfunction

    // Advance the writer list by one clock using the current fire inputs.
    task automatic model_clock();
        fl_t nq[$];
        fl_t it;
        if (reset) begin
            inflight.delete();
        end else begin
            foreach (inflight[i]) begin
                it = inflight[i];
                if (it.stg == 3) begin
                    if (!mem_fire && !wb_fire) nq.push_back(it);
                end else if (it.stg == 2) begin
                    if (mem_fire) begin
                        it.stg = 3;
                        nq.push_back(it);
                    end else if (!exe_fire) begin
                        nq.push_back(it);
                    end
                end else begin
                    if (exe_fire) begin
                        it.stg = 2;
                        nq.push_back(it);
                    end else if (!id_fire) begin
                        nq.push_back(it);
                    end
                end
            end
            if (id_fire && id_w_addr != 5'd0 && id_w_stage != 3'b000) begin
                it.dst = int'(id_w_addr);
                it.rdy = stage_num(id_w_stage);
                it.stg = 1;
                nq.push_back(it);
            end
            inflight = nq;
        end
    endtask

    // Youngest producer of 'a' decides: forwarded from its stage once its
    // result exists there, otherwise stall.
    function automatic void model_src(input int a, output int sel, output bit stall);
        int best;
        sel   = 0;
        stall = 1'b0;
        best  = 0;
        if (a != 0) begin
            foreach (inflight[i]) begin
                if (inflight[i].dst == a && (best == 0 || inflight[i].stg < best)) begin
                    best = inflight[i].stg;
                    if (FWD && inflight[i].rdy <= inflight[i].stg) begin
                        sel   = inflight[i].stg;
                        stall = 1'b0;
                    end else begin
                        sel   = 0;
                        stall = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the writer-list model.
    always @(negedge clk) begin
        int  e1, e2;
        bit  st1, st2;
        if (chk_en) begin
            model_src(int'(id_r_addr1), e1, st1);
            model_src(int'(id_r_addr2), e2, st2);
            check("cyc_stall", {3'b000, id_stall}, {3'b000, id_valid & (st1 | st2)});
            check("cyc_src1", {2'b00, src1_sel}, id_valid ? 4'(e1) : 4'd0);
            check("cyc_src2", {2'b00, src2_sel}, id_valid ? 4'(e2) : 4'd0);
            if (id_valid && id_fire) check("fire_while_stall", {3'b000, id_stall}, 4'd0);
        end
    end

    task automatic drive(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] wa, input logic [2:0] ws, input logic idf,
                         input logic ef, input logic mf, input logic wf);
        id_valid   = v;
        id_r_addr1 = a1;
        id_r_addr2 = a2;
        id_w_addr  = wa;
        id_w_stage = ws;
        id_fire    = idf;
        exe_fire   = ef;
        mem_fire   = mf;
        wb_fire    = wf;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic pin(input string name, input int st, input int s1, input int s2);
        #1;
        check({name, "_stall"}, {3'b000, id_stall}, 4'(st));
        check({name, "_src1"}, {2'b00, src1_sel}, 4'(s1));
        check({name, "_src2"}, {2'b00, src2_sel}, 4'(s2));
    endtask

    task automatic drain();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // Empty scoreboard after reset: reads never stall.
        drive(1'b1, 5'd3, 5'd5, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        pin("reset_idle", 0, 0, 0);

        // add.w r3 in E, dependent read of r3.
        drive(1'b1, 5'd0, 5'd0, 5'd3, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        pin("exe_fwd", FWD ? 0 : 1, FWD ? 1 : 0, 0);
        drain();

        // ld.w r5: load-use on src2 as the load walks E, M, W.
        drive(1'b1, 5'd0, 5'd0, 5'd5, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd5, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        pin("ld_use_E", 1, 0, 0);
        tick();
        drive(1'b1, 5'd0, 5'd5, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        pin("ld_use_M", FWD ? 0 : 1, 0, FWD ? 2 : 0);
        tick();
        drive(1'b1, 5'd0, 5'd5, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        pin("ld_use_W", FWD ? 0 : 1, 0, FWD ? 3 : 0);
        tick();
        drive(1'b1, 5'd0, 5'd5, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        pin("ld_use_done", 0, 0, 0);
        drain();

        // addi r4: producer retires over three cycles.
        drive(1'b1, 5'd0, 5'd0, 5'd4, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd4, 5'd0, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        pin("r4_E", FWD ? 0 : 1, FWD ? 1 : 0, 0);
        tick();
        drive(1'b1, 5'd4, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        pin("r4_M", FWD ? 0 : 1, FWD ? 2 : 0, 0);
        tick();
        drive(1'b1, 5'd4, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        pin("r4_W", FWD ? 0 : 1, FWD ? 3 : 0, 0);
        tick();
        drive(1'b1, 5'd4, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        pin("r4_retired", 0, 0, 0);
        drain();

        // r7 written by ld in W and addi in E: youngest wins.
        drive(1'b1, 5'd0, 5'd0, 5'd7, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd7, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd7, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        pin("youngest_r7", FWD ? 0 : 1, FWD ? 1 : 0, 0);
        drain();

        // Non-writers: waddr 0 and a zero stage code never create producers.
        drive(1'b1, 5'd0, 5'd0, 5'd0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd9, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
        pin("read_r0", 0, 0, 0);
        tick();
        drive(1'b1, 5'd9, 5'd9, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        pin("non_writer_r9", 0, 0, 0);
        drain();

        // Fill E/M/W with r10/r11/r12 (simultaneous id/exe/mem fires), then reset.
        drive(1'b1, 5'd0, 5'd0, 5'd12, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd11, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd10, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd10, 5'd12, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        pin("full_pre_reset", FWD ? 0 : 1, FWD ? 1 : 0, FWD ? 3 : 0);
        drive(1'b1, 5'd11, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        pin("full_mid_r11", FWD ? 0 : 1, FWD ? 2 : 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 5'd10, 5'd12, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        pin("post_reset", 0, 0, 0);
        tick();
        drive(1'b1, 5'd11, 5'd10, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        pin("post_reset2", 0, 0, 0);
        drain();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
